// File: rtl/clk_div_multi_if.sv
// ---------------------------------------------------------------------------
// clk_div_multi_if
// Bundle of control and status signals for the multi-channel clock divider.
//   en        : per-channel enable
//   sync      : restart all running channels at phase 0
//   period_in : packed per-channel period, channel i in [i*WIDTH +: WIDTH]
//   duty_in   : packed per-channel high count, same packing
//   clk_out   : per-channel divided waveform (registered)
//   tick      : per-channel one-cycle pulse in the last cycle of a period
//   counter   : packed per-channel phase count
// master drives the configuration, slave is the divider itself.
// ---------------------------------------------------------------------------
interface clk_div_multi_if #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 11
);
    logic [N_CH-1:0]       en;
    logic                  sync;
    logic [N_CH*WIDTH-1:0] period_in;
    logic [N_CH*WIDTH-1:0] duty_in;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
    logic [N_CH*WIDTH-1:0] counter;

    modport master (
        output en, sync, period_in, duty_in,
        input  clk_out, tick, counter
    );

    modport slave (
        input  en, sync, period_in, duty_in,
        output clk_out, tick, counter
    );
endinterface

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// Multi-channel programmable divided-clock / tick generator. Each channel
// runs a phase counter over a shadowed period and high count; new settings
// are only picked up when idle, on a period wrap or on sync, so a period in
// progress always finishes at its old length and duty.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : clk_div_multi_if.slave (en, sync, period_in, duty_in in;
//          clk_out, tick, counter out)
//
// State (per channel):
//   state  | meaning
//   IDLE   | channel stopped, outputs low, shadows track the inputs
//   RUN    | counting 0 .. P_act-1, clk_out high while cnt < H_act
// ---------------------------------------------------------------------------
module clk_div_multi #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    clk_div_multi_if.slave   bus
);

    localparam logic             S_IDLE = 1'b0;
    localparam logic             S_RUN  = 1'b1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [N_CH-1:0]             run_q;
    logic [N_CH-1:0]             run_d;
    logic [N_CH-1:0][WIDTH-1:0]  cnt_q;
    logic [N_CH-1:0][WIDTH-1:0]  cnt_d;
    logic [N_CH-1:0][WIDTH-1:0]  p_q;
    logic [N_CH-1:0][WIDTH-1:0]  p_d;
    logic [N_CH-1:0][WIDTH-1:0]  h_q;
    logic [N_CH-1:0][WIDTH-1:0]  h_d;
    logic [N_CH-1:0]             clk_out_q;
    logic [N_CH-1:0]             clk_out_d;
    logic [N_CH-1:0]             tick_q;
    logic [N_CH-1:0]             tick_d;

    logic [N_CH-1:0][WIDTH-1:0]  period_v;
    logic [N_CH-1:0][WIDTH-1:0]  duty_v;
    logic [N_CH-1:0]             wrap;

    assign period_v = bus.period_in;
    assign duty_v   = bus.duty_in;

    // Last cycle of the active period; only meaningful in RUN where p_q >= 1.
    always_comb begin
        wrap = '0;
        for (int i = 0; i < N_CH; i++) begin
            wrap[i] = (cnt_q[i] == (p_q[i] - ONE));
        end
    end

    // State register, including the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= '0;
            cnt_q     <= '0;
            p_q       <= '0;
            h_q       <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            h_q       <= h_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    // Next-state logic. Within RUN: disable beats sync, sync beats wrap;
    // sync and wrap produce the same restart so their overlap is harmless.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        h_d   = h_q;
        for (int i = 0; i < N_CH; i++) begin
            if (run_q[i] == S_IDLE) begin
                cnt_d[i] = '0;
                p_d[i]   = period_v[i];
                h_d[i]   = duty_v[i];
                run_d[i] = (bus.en[i] && (period_v[i] != '0)) ? S_RUN : S_IDLE;
            end else if (!bus.en[i]) begin
                run_d[i] = S_IDLE;
                cnt_d[i] = '0;
            end else if (bus.sync || wrap[i]) begin
                cnt_d[i] = '0;
                p_d[i]   = period_v[i];
                h_d[i]   = duty_v[i];
                if (period_v[i] == '0) begin
                    run_d[i] = S_IDLE;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
        end
    end

    // Output decode on the next state so the pins come straight from flops
    // and line up with the counter value they describe.
    always_comb begin
        clk_out_d = '0;
        tick_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            clk_out_d[i] = (run_d[i] == S_RUN) && (cnt_d[i] < h_d[i]);
            tick_d[i]    = (run_d[i] == S_RUN) && (cnt_d[i] == (p_d[i] - ONE));
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.counter = cnt_q;

endmodule
